regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 68 ++++++
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared instruction field positions, size defaults and index-width helper for regfile_sb
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int FIELD_W = 5;

    // Register index width for a given register count
    function automatic int aw_of(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy-bit scoreboard, pending counter, sticky writeback error and issue hazard check
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter bit BYPASS = 1'b0,
    localparam int AW    = aw_of(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    input  logic          issue_valid,
    input  logic          rd_we,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    output logic          issue_ready,
    output logic [AW:0]   pending,
    output logic          wb_err
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic            wb_hit;
    logic            hz1;
    logic            hz2;
    logic            hzd;
    logic            set_en;
    logic            inc;
    logic            dec;

    assign wb_hit = wb_valid && (wb_addr != '0);

    // Hazard detection: a busy source or destination stalls unless a bypassed writeback resolves it now
    always_comb begin
        hz1         = busy[rs1] && !(BYPASS && wb_hit && wb_addr == rs1);
        hz2         = busy[rs2] && !(BYPASS && wb_hit && wb_addr == rs2);
        hzd         = rd_we && busy[rd] && !(BYPASS && wb_hit && wb_addr == rd);
        issue_ready = !(hz1 || hz2 || hzd);
    end

    // Set/clear vectors and counter deltas; a set on the register being cleared wins
    always_comb begin
        set_en  = issue_valid && issue_ready && rd_we && (rd != '0);
        clr_vec = '0;
        set_vec = '0;
        clr_vec[wb_addr] = wb_hit;
        set_vec[rd]      = set_en;
        inc = set_en && !busy[rd];
        dec = wb_hit && busy[wb_addr] && !(set_en && rd == wb_addr);
    end

    // Scoreboard state: busy bits, popcount tracker and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy    <= '0;
            pending <= '0;
            wb_err  <= 1'b0;
        end else begin
            busy    <= (busy & ~clr_vec) | set_vec;
            pending <= pending + (AW+1)'(inc) - (AW+1)'(dec);
            wb_err  <= wb_err || (wb_hit && !busy[wb_addr]);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with issue scoreboard; define REGFILE_SB_BYPASS_EN to forward writeback data to reads and hazards
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    localparam int AW  = aw_of(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [31:0]     ir_i,
    input  logic            issue_valid_i,
    input  logic            rd_we_i,
    output logic            issue_ready_o,
    output logic [XLEN-1:0] ra_o,
    output logic [XLEN-1:0] rb_o,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [AW:0]     pending_o,
    output logic            wb_err_o
);

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            wb_hit;
    logic            unused_ok;

    assign rs1       = ir_i[RS1_LSB +: AW];
    assign rs2       = ir_i[RS2_LSB +: AW];
    assign rd        = ir_i[RD_LSB +: AW];
    assign wb_hit    = wb_valid_i && (wb_addr_i != '0);
    assign unused_ok = ^ir_i;

    // Storage: register 0 is never written so it stays at its reset value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Read muxes: register 0 reads zero, optional same-cycle forwarding from the writeback port
    always_comb begin
        ra_o = (rs1 == '0) ? '0 : (BYPASS && wb_hit && wb_addr_i == rs1) ? wb_data_i : regs[rs1];
        rb_o = (rs2 == '0) ? '0 : (BYPASS && wb_hit && wb_addr_i == rs2) ? wb_data_i : regs[rs2];
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .issue_valid (issue_valid_i),
        .rd_we       (rd_we_i),
        .wb_valid    (wb_valid_i),
        .wb_addr     (wb_addr_i),
        .issue_ready (issue_ready_o),
        .pending     (pending_o),
        .wb_err      (wb_err_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: checks a 32x32 and a 16-bit x 8 instance against a behavioural register/scoreboard model
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        iv;
    logic        we;
    logic        wbv;
    logic [4:0]  wa;
    logic [31:0] wd;

    logic [31:0] b_ra, b_rb;
    logic        b_rdy, b_err;
    logic [5:0]  b_pend;
    logic [15:0] s_ra, s_rb;
    logic        s_rdy, s_err;
    logic [3:0]  s_pend;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREG(32)) dut_big (
        .clk(clk), .reset_n(reset_n), .ir_i(ir), .issue_valid_i(iv), .rd_we_i(we),
        .issue_ready_o(b_rdy), .ra_o(b_ra), .rb_o(b_rb), .wb_valid_i(wbv),
        .wb_addr_i(wa), .wb_data_i(wd), .pending_o(b_pend), .wb_err_o(b_err)
    );

    regfile_sb #(.XLEN(16), .NREG(8)) dut_small (
        .clk(clk), .reset_n(reset_n), .ir_i(ir), .issue_valid_i(iv), .rd_we_i(we),
        .issue_ready_o(s_rdy), .ra_o(s_ra), .rb_o(s_rb), .wb_valid_i(wbv),
        .wb_addr_i(wa[2:0]), .wb_data_i(wd[15:0]), .pending_o(s_pend), .wb_err_o(s_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 is the 32x32 instance, index 1 the 16x8 instance
    bit          mb [2][32];
    logic [31:0] mr [2][32];
    bit          me [2];

    function automatic int nr(input int c);
        return (c == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] msk(input int c);
        return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic int fld(input int c, input int lsb);
        int v;
        v = int'((ir >> lsb) & 32'h1f);
        return v % nr(c);
    endfunction

    function automatic int wac(input int c);
        return int'(wa) % nr(c);
    endfunction

    function automatic bit stall_on(input int c, input int i);
        return mb[c][i] && !(BYP && wbv && wac(c) != 0 && wac(c) == i);
    endfunction

    function automatic bit m_ready(input int c);
        return !(stall_on(c, fld(c, 15)) || stall_on(c, fld(c, 20)) || (we && stall_on(c, fld(c, 7))));
    endfunction

    function automatic logic [31:0] m_read(input int c, input int i);
        if (i == 0) return 32'h0;
        if (BYP && wbv && wac(c) == i) return wd & msk(c);
        return mr[c][i];
    endfunction

    function automatic int m_pend(input int c);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mb[c][i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            me[c] = 1'b0;
            for (int i = 0; i < 32; i++) begin
                mb[c][i] = 1'b0;
                mr[c][i] = 32'h0;
            end
        end
    endtask

    task automatic m_update(input int c);
        bit f;
        int a, d;
        f = iv && m_ready(c);
        a = wac(c);
        d = fld(c, 7);
        if (wbv && a != 0) begin
            if (!mb[c][a]) me[c] = 1'b1;
            mr[c][a] = wd & msk(c);
            mb[c][a] = 1'b0;
        end
        if (f && we && d != 0) mb[c][d] = 1'b1;
    endtask

    task automatic check_all();
        chk("big_ready", b_rdy, m_ready(0));
        chk("big_ra", b_ra, m_read(0, fld(0, 15)));
        chk("big_rb", b_rb, m_read(0, fld(0, 20)));
        chk("big_pending", b_pend, m_pend(0));
        chk("big_err", b_err, me[0]);
        chk("small_ready", s_rdy, m_ready(1));
        chk("small_ra", s_ra, m_read(1, fld(1, 15)));
        chk("small_rb", s_rb, m_read(1, fld(1, 20)));
        chk("small_pending", s_pend, m_pend(1));
        chk("small_err", s_err, me[1]);
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input bit v, input bit w,
                         input bit bv, input int a, input logic [31:0] d);
        ir  = {7'h0, 5'(rs2), 5'(rs1), 3'h0, 5'(rd), 7'h33};
        iv  = v;
        we  = w;
        wbv = bv;
        wa  = 5'(a);
        wd  = d;
    endtask

    // Called shortly after a falling edge: compare, advance the model across the rising edge
    task automatic step();
        check_all();
        if (reset_n) begin
            m_update(0);
            m_update(1);
        end
        @(negedge clk);
    endtask

    task automatic tick();
        #2;
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_reset();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        int rs1, rs2, rd;
        bit iv, we, wbv;
        int wa;
        logic [31:0] wd, ra_n, ra_b;
        bit rdy_n, rdy_b;
        int pd_n, pd_b;
        bit err;
    } vec_t;

    vec_t tv [13];

    initial begin
        tv[0]  = '{5, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1, 1, 0, 0, 0};
        tv[1]  = '{0, 0, 3, 1, 1, 0, 0, 32'h0,         32'h0,         32'h0,         1, 1, 0, 0, 0};
        tv[2]  = '{3, 0, 0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 1, 1, 0};
        tv[3]  = '{3, 0, 0, 1, 0, 1, 3, 32'hDEADBEEF,  32'h0,         32'hDEADBEEF,  0, 1, 1, 1, 0};
        tv[4]  = '{3, 0, 0, 1, 0, 0, 0, 32'h0,         32'hDEADBEEF,  32'hDEADBEEF,  1, 1, 0, 0, 0};
        tv[5]  = '{0, 0, 7, 1, 1, 0, 0, 32'h0,         32'h0,         32'h0,         1, 1, 0, 0, 0};
        tv[6]  = '{0, 0, 7, 1, 1, 1, 7, 32'h77,        32'h0,         32'h0,         0, 1, 1, 1, 0};
        tv[7]  = '{7, 0, 0, 0, 0, 0, 0, 32'h0,         32'h77,        32'h77,        1, 0, 0, 1, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 1, 0, 32'h1234,      32'h0,         32'h0,         1, 1, 0, 1, 0};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1, 1, 0, 1, 0};
        tv[10] = '{0, 0, 0, 0, 0, 1, 9, 32'h5,         32'h0,         32'h0,         1, 1, 0, 1, 0};
        tv[11] = '{9, 0, 0, 0, 0, 0, 0, 32'h0,         32'h5,         32'h5,         1, 1, 0, 1, 1};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1, 1, 0, 1, 1};

        m_reset();
        reset_n = 1'b0;
        drive(5, 0, 0, 0, 0, 0, 0, 32'h0);
        tick();
        chk("reset_ready", b_rdy, 1'b1);
        chk("reset_pending", b_pend, 6'd0);
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].iv, tv[i].we, tv[i].wbv, tv[i].wa, tv[i].wd);
            #2;
            chk($sformatf("vec%0d_ra", i), b_ra, BYP ? tv[i].ra_b : tv[i].ra_n);
            chk($sformatf("vec%0d_ready", i), b_rdy, BYP ? tv[i].rdy_b : tv[i].rdy_n);
            chk($sformatf("vec%0d_pending", i), b_pend, BYP ? tv[i].pd_b : tv[i].pd_n);
            chk($sformatf("vec%0d_err", i), b_err, tv[i].err);
            step();
        end

        do_reset();
        chk("err_cleared", b_err, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 5, 32'hCAFE_1234);
        tick();
        drive(13, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("big_rs13_reads_reg13", b_ra, 32'h0);
        chk("small_rs13_reads_reg5", s_ra, 16'h1234);
        step();

        for (int r = 1; r < 32; r++) begin
            drive(0, 0, r, 1, 1, 0, 0, 32'h0);
            #2;
            chk("b2b_ready", b_rdy, 1'b1);
            step();
        end
        drive(5, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("b2b_big_pending_full", b_pend, 6'd31);
        chk("b2b_small_pending_full", s_pend, 4'd7);
        chk("b2b_big_ra_reg5", b_ra, 32'hCAFE_1234);
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("async_big_pending", b_pend, 6'd0);
        chk("async_small_pending", s_pend, 4'd0);
        chk("async_big_ra", b_ra, 32'h0);
        chk("async_small_ra", s_ra, 16'h0);
        chk("async_ready", b_rdy, 1'b1);
        @(negedge clk);
        drive(5, 0, 0, 0, 0, 1, 5, 32'hFFFF_FFFF);
        tick();
        reset_n = 1'b1;
        drive(5, 0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("wb_in_reset_ignored", b_ra, 32'h0);
        step();

        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 31);
            for (int j = 0; j < 32; j++) begin
                if (mb[0][(k + j) % 32]) begin
                    k = (k + j) % 32;
                    break;
                end
            end
            ir  = $urandom;
            iv  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            wbv = ($urandom_range(0, 3) != 0);
            wa  = 5'(k);
            wd  = $urandom;
            if ($urandom_range(0, 63) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
